// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings, FSM state
// encoding and the alignment helper used by the accept-time fault check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStoreRd,
    StStoreWr,
    StResp
  } lsu_state_e;

  // funct3[1:0] gives the access size for both loads and stores (B/BU, H/HU, W).
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'd1:    mis = addr_lo[0];
      2'd2:    mis = (addr_lo != 2'd0);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for sub-word accesses.
//   funct3_i     RV32I funct3 of the access
//   addr_lo_i    byte offset within the word
//   mem_word_i   word read from data memory
//   store_data_i right-justified store data
//   load_data_o  selected lane, sign/zero-extended per funct3
//   store_word_o mem_word_i with the addressed byte/half replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] mem_word_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    unique case (addr_lo_i)
      2'd0: byte_lane = mem_word_i[7:0];
      2'd1: byte_lane = mem_word_i[15:8];
      2'd2: byte_lane = mem_word_i[23:16];
      2'd3: byte_lane = mem_word_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
  end

  always_comb begin
    load_data_o = mem_word_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data_o = {24'h000000, byte_lane};
      F3_H:    load_data_o = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data_o = {16'h0000, half_lane};
      default: load_data_o = mem_word_i;
    endcase
  end

  always_comb begin
    store_word_o = mem_word_i;
    case (funct3_i[1:0])
      2'd0: begin
        unique case (addr_lo_i)
          2'd0: store_word_o[7:0]   = store_data_i[7:0];
          2'd1: store_word_o[15:8]  = store_data_i[7:0];
          2'd2: store_word_o[23:16] = store_data_i[7:0];
          2'd3: store_word_o[31:24] = store_data_i[7:0];
        endcase
      end
      2'd1: begin
        if (addr_lo_i[1]) store_word_o[31:16] = store_data_i[15:0];
        else              store_word_o[15:0]  = store_data_i[15:0];
      end
      default: store_word_o = store_data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between the MEM pipeline register and a word-wide
// data memory. Sub-word stores are done as read-modify-write.
//   clk, rst            clock and synchronous active-high reset
//   req_*               request handshake and fields (captured on accept)
//   resp_valid/rdata/fault  one-cycle completion pulse with result
//   dmem_*              word-wide data memory interface (combinational read)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 1024,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata
);

  lsu_state_e            state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           merge_q, merge_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  fault_q, fault_d;

  logic [31:0]           load_data;
  logic [31:0]           store_word;
  logic [ADDR_WIDTH-1:0] req_word_idx;
  logic                  req_illegal;
  logic                  req_fault;

  lsu_lane_align u_lane_align (
    .funct3_i     (funct3_q),
    .addr_lo_i    (addr_q[1:0]),
    .mem_word_i   (dmem_rdata),
    .store_data_i (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  // Accept-time fault check, evaluated on the live request fields.
  always_comb begin
    req_word_idx = req_addr >> 2;
    if (req_we) req_illegal = (req_funct3 > F3_W);
    else        req_illegal = (req_funct3 == 3'd3) || (req_funct3 >= 3'd6);
    req_fault = is_misaligned(req_funct3, req_addr[1:0]) || req_illegal ||
                (req_word_idx >= ADDR_WIDTH'(DMEM_WORDS));
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (req_fault) begin
            fault_d = 1'b1;
            state_d = StResp;
          end else if (!req_we) begin
            state_d = StLoad;
          end else if (req_funct3 == F3_W) begin
            merge_d = req_wdata;
            state_d = StStoreWr;
          end else begin
            state_d = StStoreRd;
          end
        end
      end
      StLoad: begin
        rdata_d = load_data;
        state_d = StResp;
      end
      StStoreRd: begin
        merge_d = store_word;
        state_d = StStoreWr;
      end
      StStoreWr: state_d = StResp;
      StResp: begin
        // Clear on the way back to idle so stores/faults always report zero data.
        rdata_d = 32'h0;
        fault_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  // Strobes gated by rst so an abandoned store can never commit.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = !rst && (state_q == StResp);
    resp_rdata = rdata_q;
    resp_fault = fault_q;
    dmem_read  = !rst && ((state_q == StLoad) || (state_q == StStoreRd));
    dmem_write = !rst && (state_q == StStoreWr);
    dmem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    dmem_wdata = merge_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(
    .DMEM_WORDS (1024),
    .ADDR_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  // Data memory model: combinational read, write on rising edge.
  logic [31:0] mem [0:1023];
  assign dmem_rdata = mem[dmem_addr[11:2]];
  always @(posedge clk) if (dmem_write) mem[dmem_addr[11:2]] <= dmem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          tests = 0;
  int          fails = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wd = 32'h0;

  always @(negedge clk) begin
    if (dmem_read) rd_cnt++;
    if (dmem_write) begin
      wr_cnt++;
      last_wd = dmem_wdata;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          at;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops an expectation for every response the DUT presents.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected resp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
        check("resp cycle", cyc, e.at);
      end
    end
  end

  // lat: cycles from accept edge to the resp_valid cycle.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_f,
                       input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready timeout", 32'd0, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    sb.push_back('{exp_rd, exp_f, cyc + lat - 1});
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("response timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_f,
                     input int lat);
    issue(we, f3, addr, wd, exp_rd, exp_f, lat);
    wait_done();
  endtask

  initial begin
    int k;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[64] = 32'h4; mem[65] = 32'h5; mem[66] = 32'h3; mem[67] = 32'h1; mem[68] = 32'h2;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_fault", {31'd0, resp_fault}, 32'd0);
    check("reset dmem strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    check("reset dmem_addr", dmem_addr, 32'd0);
    check("reset dmem_wdata", dmem_wdata, 32'd0);
    rst = 1'b0;

    // 1: word load
    rd_cnt = 0; wr_cnt = 0;
    txn(1'b0, 3'd2, 32'h104, 32'h0, 32'h5, 1'b0, 2);
    check("LW no write", wr_cnt, 32'd0);

    // 2: byte store via read-modify-write
    rd_cnt = 0; wr_cnt = 0;
    txn(1'b1, 3'd0, 32'h101, 32'hAB, 32'h0, 1'b0, 3);
    check("SB read count", rd_cnt, 32'd1);
    check("SB write count", wr_cnt, 32'd1);
    check("SB write data", last_wd, 32'h0000AB04);
    txn(1'b0, 3'd2, 32'h100, 32'h0, 32'h0000AB04, 1'b0, 2);

    // 3: sign/zero extension and halfword store
    txn(1'b0, 3'd0, 32'h101, 32'h0, 32'hFFFFFFAB, 1'b0, 2);
    txn(1'b0, 3'd4, 32'h101, 32'h0, 32'h000000AB, 1'b0, 2);
    txn(1'b0, 3'd0, 32'h100, 32'h0, 32'h00000004, 1'b0, 2);
    rd_cnt = 0; wr_cnt = 0;
    txn(1'b1, 3'd1, 32'h102, 32'h8001, 32'h0, 1'b0, 3);
    check("SH write data", last_wd, 32'h8001AB04);
    txn(1'b0, 3'd1, 32'h102, 32'h0, 32'hFFFF8001, 1'b0, 2);
    txn(1'b0, 3'd5, 32'h102, 32'h0, 32'h00008001, 1'b0, 2);
    txn(1'b0, 3'd2, 32'h100, 32'h0, 32'h8001AB04, 1'b0, 2);

    // 4: faults never touch memory
    rd_cnt = 0; wr_cnt = 0;
    txn(1'b0, 3'd1, 32'h103, 32'h0, 32'h0, 1'b1, 1);
    txn(1'b1, 3'd2, 32'h102, 32'h12345678, 32'h0, 1'b1, 1);
    txn(1'b0, 3'd2, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
    txn(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1'b1, 1);
    txn(1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 1'b1, 1);
    check("fault read count", rd_cnt, 32'd0);
    check("fault write count", wr_cnt, 32'd0);

    // 5: req_valid held high, back-to-back loads
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h108;
    @(posedge clk);
    #1;
    k = cyc;
    sb.push_back('{32'h3, 1'b0, k + 1});
    sb.push_back('{32'h1, 1'b0, k + 4});
    req_addr = 32'h10C;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_done();

    // 6: reset during STORE_RD abandons the store
    rd_cnt = 0; wr_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h110;
    req_wdata = 32'h1234;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("req_ready after reset", {31'd0, req_ready}, 32'd1);
    repeat (5) @(negedge clk);
    check("abandoned store writes", wr_cnt, 32'd0);
    check("word 0x110 unchanged", mem[68], 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
